control_botones: RTL and testbench
==================================

# control_botones

Button-event controller that sits between the debounced button outputs and the game/display logic. It samples N debounced button levels on the millisecond enable from the clock divider and arbitrates simultaneous presses by fixed priority. Each press is classified as short or long, and is delivered as a single event over a valid/ack handshake. Further presses are locked out until the consumer acknowledges the event and all buttons are released.

## Interface

Parameters:
- `N_BTN`, default 4: number of debounced button inputs.
- `CODE_W`, default 2: width of the event code. Must satisfy 2^CODE_W ≥ N_BTN.
- `LONG_MS`, default 3000: number of held samples (ms ticks) that make a press long. Must be ≥ 2.
- `CNT_W`, default 12: hold-counter width. Must satisfy 2^CNT_W > LONG_MS.

Ports:
- `clk`, input, 1: system clock (50 MHz).
- `reset`, input, 1: synchronous, active-high reset.
- `tick_ms`, input, 1: one-`clk`-wide sample enable, once per ms, from the divider.
- `btn`, input, N_BTN: debounced button levels, 1 = pressed. Already synchronous to `clk`.
- `evt_ack`, input, 1: consumer accepts the event. Effective only while `evt_valid`=1.
- `evt_valid`, output, 1: an event is pending.
- `evt_code`, output, CODE_W: index of the button that produced the event.
- `evt_long`, output, 1: 1 = long press, 0 = short press.
- `busy`, output, 1: 1 whenever the FSM is not in IDLE.

## Operation

The FSM has four states: IDLE, HELD, WAIT_ACK, RELEASE. All outputs are registered. `btn` is examined only on cycles with `tick_ms`=1.

- **IDLE**
  - On a tick with `btn` ≠ 0: grant goes to the lowest set index, `grant` ← that index, `cnt` ← 1, next state HELD.
  - Otherwise remain in IDLE.
- **HELD**
  - On a tick with `btn[grant]`=1: `cnt` ← `cnt`+1. If the new `cnt` equals LONG_MS, set `evt_long`=1, `evt_code`=`grant`, `evt_valid`=1, next state WAIT_ACK.
  - On a tick with `btn[grant]`=0: set `evt_long`=0, `evt_code`=`grant`, `evt_valid`=1, next state WAIT_ACK.
  - Other buttons are ignored while in HELD.
- **WAIT_ACK**
  - `evt_valid`, `evt_code` and `evt_long` are held stable.
  - On any cycle with `evt_ack`=1 (no tick needed): `evt_valid` ← 0, next state RELEASE.
- **RELEASE**
  - On a tick with `btn` = 0: next state IDLE.
  - A button still held, or a new press, keeps the FSM in RELEASE. No event is generated until a fresh press from IDLE.

Classification rules:
- A press is short if the button is released before LONG_MS consecutive held samples, counting the grant sample as sample 1.
- A press is long when the LONG_MS-th held sample is reached. The long event is emitted at that point while the button is still held; the eventual release produces no further event.
- `cnt` never exceeds LONG_MS and does not wrap.

Outputs:
- `busy` = (state ≠ IDLE), registered alongside the state.
- `evt_code` and `evt_long` keep their last values after the handshake completes.

## Timing

Reset values (a synchronous `reset`=1 overrides every other input, including `tick_ms` and `evt_ack`):
- state IDLE, `cnt`=0, `grant`=0.
- `evt_valid`=0, `evt_code`=0, `evt_long`=0, `busy`=0.

Latencies:
- A grant tick at edge k gives `busy`=1 after edge k.
- A deciding tick at edge k gives `evt_valid`=1 after edge k (1 clk).
- `evt_ack` sampled high at edge k gives `evt_valid`=0 after edge k. The minimum valid pulse is 1 clk, for an ack presented in the first valid cycle.

Boundary conditions:
- `evt_ack` while `evt_valid`=0 has no effect.
- `evt_ack` held high continuously completes the handshake in the first valid cycle.
- Simultaneous presses on the same tick: the lowest index wins, and the others are never reported for that press.
- A press shorter than one tick period may be missed. This is acceptable because debounced inputs are ≥ 10 ms.
- A button that is already high when reset deasserts is granted on the first tick.
- A tick in the same cycle as `evt_ack` in WAIT_ACK: the ack is taken, and `btn` is first evaluated for release on the next tick.
- Reset mid-press (HELD or WAIT_ACK) drops the pending event, with no pulse on `evt_valid`.

## Test plan

All scenarios use LONG_MS=5, N_BTN=4, and `tick_ms` every 10 clk.

1. **Short press.** `btn`=0010 for 3 ticks, then 0000; ack 2 clk after valid. Required: one event with `evt_code`=1 and `evt_long`=0; `evt_valid`=1 exactly 1 clk after the release tick; `evt_valid` falls the cycle after ack; `busy`=0 after the next tick.
2. **Long press.** `btn`=1000 held for 12 ticks with immediate ack. Required: event with `evt_code`=3 and `evt_long`=1, asserted 1 clk after the 5th held tick while still pressed; no event on release; `busy` stays 1 until the first tick after release.
3. **Simultaneous press.** `btn`=0110 on the same tick, 2 ticks, then 0000. Required: a single event with `evt_code`=1 and `evt_long`=0; button 2 is not reported.
4. **Late ack.** Short press on button 0 with ack delayed 50 clk. Required: `evt_valid`, `evt_code`=0 and `evt_long`=0 stable for all 50 clk; a button-3 press during that wait produces no event and keeps the FSM in RELEASE until `btn`=0.
5. **Boundary press length.** Button 1 held exactly 4 ticks, then exactly 5 ticks. Required: the 4-tick press gives `evt_long`=0; the 5-tick press gives `evt_long`=1.
6. **Reset mid-press.** Assert `reset` 1 clk during HELD, then during WAIT_ACK. Required: all outputs 0 on the next cycle, with no event emitted; a held button re-grants on the first tick after reset.

Source files
------------

// File: rtl/control_botones_if.sv
// Event handshake between the button controller and its consumer.
interface control_botones_if #(
  parameter int CODE_W = 2
);
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_long;
  logic              evt_ack;

  modport master (output evt_valid, output evt_code, output evt_long, input evt_ack);
  modport slave  (input evt_valid, input evt_code, input evt_long, output evt_ack);
endinterface

// File: rtl/control_botones.sv
// Button-event controller: samples debounced buttons on tick_ms, grants the
// lowest pressed index, classifies short/long presses and hands one event out
// over valid/ack, then locks out until every button is released.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no press in progress, waiting for any button on a tick
// HELD     | granted button held, counting samples toward LONG_MS
// WAIT_ACK | event pending on evt_valid, waiting for evt_ack
// RELEASE  | event consumed, waiting for a tick with all buttons low
module control_botones #(
  parameter int N_BTN   = 4,
  parameter int CODE_W  = 2,
  parameter int LONG_MS = 3000,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_ms,
  input  logic [N_BTN-1:0]   btn,
  output logic               busy,
  control_botones_if.master  evt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] grant, grant_n;
  logic              valid_q, valid_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic              long_q, long_n;
  logic [CODE_W-1:0] low_idx;
  logic [CNT_W-1:0]  cnt_inc;

  // Lowest set button index; scanning downward lets the lowest index win.
  always_comb begin
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn[i]) low_idx = CODE_W'(i);
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant;
    valid_n = valid_q;
    code_n  = code_q;
    long_n  = long_q;
    case (state)
      IDLE: begin
        if (tick_ms && (btn != '0)) begin
          grant_n = low_idx;
          cnt_n   = CNT_W'(1);
          state_n = HELD;
        end
      end
      HELD: begin
        if (tick_ms) begin
          if (btn[grant]) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(LONG_MS)) begin
              long_n  = 1'b1;
              code_n  = grant;
              valid_n = 1'b1;
              state_n = WAIT_ACK;
            end
          end else begin
            long_n  = 1'b0;
            code_n  = grant;
            valid_n = 1'b1;
            state_n = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (evt.evt_ack) begin
          valid_n = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (tick_ms && (btn == '0)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; busy is derived from the next state so it
  // lines up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      grant   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      long_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      grant   <= grant_n;
      valid_q <= valid_n;
      code_q  <= code_n;
      long_q  <= long_n;
      busy    <= (state_n != IDLE);
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_code  = code_q;
  assign evt.evt_long  = long_q;

endmodule

// File: tb/tb_control_botones.sv
// Directed bench for control_botones with LONG_MS=5, N_BTN=4, ticks every 10 clk.
module tb_control_botones;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_ms;
  logic [3:0] btn;
  logic       busy;
  int         n_chk = 0;
  int         n_err = 0;

  control_botones_if #(.CODE_W(2)) evt_if ();

  control_botones #(
    .N_BTN(4), .CODE_W(2), .LONG_MS(5), .CNT_W(12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick_ms (tick_ms),
    .btn     (btn),
    .busy    (busy),
    .evt     (evt_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Nine quiet cycles then one tick cycle; returns 1 time unit after the tick edge.
  task automatic tick();
    tick_ms = 1'b0;
    clk_n(9);
    tick_ms = 1'b1;
    clk_n(1);
    tick_ms = 1'b0;
  endtask

  task automatic ack_pulse();
    evt_if.evt_ack = 1'b1;
    clk_n(1);
    evt_if.evt_ack = 1'b0;
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] code, input logic lng);
    chk({tag, " valid"}, 16'(evt_if.evt_valid), 16'd1);
    chk({tag, " code"},  16'(evt_if.evt_code),  16'(code));
    chk({tag, " long"},  16'(evt_if.evt_long),  16'(lng));
  endtask

  logic stable;

  initial begin
    reset = 1'b1;
    tick_ms = 1'b0;
    btn = 4'b0000;
    evt_if.evt_ack = 1'b0;
    clk_n(3);
    reset = 1'b0;
    chk("rst valid", 16'(evt_if.evt_valid), 16'd0);
    chk("rst code",  16'(evt_if.evt_code),  16'd0);
    chk("rst long",  16'(evt_if.evt_long),  16'd0);
    chk("rst busy",  16'(busy),             16'd0);

    // 1: short press on button 1
    btn = 4'b0010;
    tick();
    chk("s1 grant busy", 16'(busy), 16'd1);
    tick();
    tick();
    chk("s1 no early valid", 16'(evt_if.evt_valid), 16'd0);
    btn = 4'b0000;
    tick();
    chk_evt("s1", 2'd1, 1'b0);
    clk_n(1);
    chk("s1 valid held", 16'(evt_if.evt_valid), 16'd1);
    ack_pulse();
    chk("s1 valid drop", 16'(evt_if.evt_valid), 16'd0);
    chk("s1 busy release", 16'(busy), 16'd1);
    tick();
    chk("s1 idle", 16'(busy), 16'd0);

    // 2: long press on button 3 with ack held high
    btn = 4'b1000;
    evt_if.evt_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("s2 no valid at 4", 16'(evt_if.evt_valid), 16'd0);
    tick();
    chk_evt("s2", 2'd3, 1'b1);
    clk_n(1);
    chk("s2 ack immediate", 16'(evt_if.evt_valid), 16'd0);
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (evt_if.evt_valid !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    chk("s2 held no event", 16'(stable), 16'd1);
    evt_if.evt_ack = 1'b0;
    btn = 4'b0000;
    clk_n(3);
    chk("s2 busy before tick", 16'(busy), 16'd1);
    tick();
    chk("s2 idle", 16'(busy), 16'd0);
    chk("s2 long kept", 16'(evt_if.evt_long), 16'd1);

    // 3: simultaneous press 0110; stray ack in HELD is ignored
    btn = 4'b0110;
    tick();
    ack_pulse();
    chk("s3 ack in held", 16'(busy), 16'd1);
    tick();
    btn = 4'b0000;
    tick();
    chk_evt("s3", 2'd1, 1'b0);
    ack_pulse();
    tick();
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (evt_if.evt_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    chk("s3 btn2 unreported", 16'(stable), 16'd1);

    // 4: late ack on button 0, button 3 pressed during the wait
    btn = 4'b0001;
    tick();
    tick();
    btn = 4'b0000;
    tick();
    chk_evt("s4", 2'd0, 1'b0);
    stable = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 20) btn = 4'b1000;
      tick_ms = (i % 10 == 0);
      clk_n(1);
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 2'd0 || evt_if.evt_long !== 1'b0)
        stable = 1'b0;
    end
    tick_ms = 1'b0;
    chk("s4 stable 50", 16'(stable), 16'd1);
    ack_pulse();
    chk("s4 valid drop", 16'(evt_if.evt_valid), 16'd0);
    tick();
    tick();
    chk("s4 locked busy", 16'(busy), 16'd1);
    chk("s4 locked no evt", 16'(evt_if.evt_valid), 16'd0);
    btn = 4'b0000;
    tick();
    chk("s4 idle", 16'(busy), 16'd0);

    // 5: 4-sample press is short, 5-sample press is long
    btn = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    chk("s5 4 no valid", 16'(evt_if.evt_valid), 16'd0);
    btn = 4'b0000;
    tick();
    chk_evt("s5 four", 2'd1, 1'b0);
    ack_pulse();
    tick();
    btn = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    chk_evt("s5 five", 2'd1, 1'b1);
    ack_pulse();
    btn = 4'b0000;
    tick();
    chk("s5 idle", 16'(busy), 16'd0);

    // 6: reset in HELD, then in WAIT_ACK
    btn = 4'b0100;
    tick();
    chk("s6 held busy", 16'(busy), 16'd1);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    chk("s6 rst1 busy", 16'(busy), 16'd0);
    chk("s6 rst1 valid", 16'(evt_if.evt_valid), 16'd0);
    tick();
    chk("s6 regrant", 16'(busy), 16'd1);
    tick();
    btn = 4'b0000;
    tick();
    chk_evt("s6 pre", 2'd2, 1'b0);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    chk("s6 rst2 valid", 16'(evt_if.evt_valid), 16'd0);
    chk("s6 rst2 code",  16'(evt_if.evt_code),  16'd0);
    chk("s6 rst2 long",  16'(evt_if.evt_long),  16'd0);
    chk("s6 rst2 busy",  16'(busy),             16'd0);
    stable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (evt_if.evt_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    chk("s6 no event", 16'(stable), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
